// File: rtl/datamem_param_if.sv
// rtl/datamem_param_if.sv - request/response, syscall and character-stream bundle for datamem_param
interface datamem_param_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        sys_valid;
    logic [31:0] sys_v;
    logic [31:0] sys_a;
    logic        sys_busy;
    logic        chr_valid;
    logic [7:0]  chr_data;
    logic        chr_ready;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output sys_valid, sys_v, sys_a, chr_ready,
        input  rsp_valid, rsp_rdata, rsp_err, stall, sys_busy, chr_valid, chr_data
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  sys_valid, sys_v, sys_a, chr_ready,
        output rsp_valid, rsp_rdata, rsp_err, stall, sys_busy, chr_valid, chr_data
    );
endinterface

// File: rtl/datamem_param.sv
// rtl/datamem_param.sv - MEM-stage data memory with RAM/MMIO windows and print-string engine
module datamem_param #(
    parameter logic [31:0] RAM_BASE   = 32'h0010_0000,
    parameter int unsigned RAM_WORDS  = 8192,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int unsigned MMIO_WORDS = 256,
    parameter int unsigned MAX_STR    = 1024
) (
    input logic            clk,
    input logic            rst_n,
    datamem_param_if.slave bus
);
    localparam int RAW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int MAW = (MMIO_WORDS > 1) ? $clog2(MMIO_WORDS) : 1;
    localparam int CW  = $clog2(MAX_STR + 1);
    localparam logic [31:0] RAM_SPAN  = 32'(RAM_WORDS * 4);
    localparam logic [31:0] MMIO_SPAN = 32'(MMIO_WORDS * 4);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_NL} state_t;

    logic [31:0] ram  [RAM_WORDS];
    logic [31:0] mmio [MMIO_WORDS];

    function automatic logic in_ram(input logic [31:0] a);
        logic [31:0] off;
        off = a - RAM_BASE;
        return off < RAM_SPAN;
    endfunction

    // engine state
    state_t         state_q, state_d;
    logic [31:0]    ptr_q;
    logic [CW-1:0]  count_q;
    logic [31:0]    buf_q;
    logic           busy;
    logic           start, fetch, adv;
    logic           chr_valid_c;
    logic [7:0]     chr_data_c, cur_byte;
    logic [31:0]    ptr_inc;
    logic [RAW-1:0] fetch_idx;

    // request side
    logic [31:0]    ram_off, mmio_off;
    logic           ram_hit, mmio_hit, misaligned, req_err, accept;
    logic [RAW-1:0] ram_idx;
    logic [MAW-1:0] mmio_idx;
    logic [3:0]     wr_be;
    logic [31:0]    wr_data, rd_word, rd_lane, ld_data;
    logic           rsp_valid_q, rsp_err_q;
    logic [31:0]    rsp_rdata_q;

    assign busy = (state_q != S_IDLE);

    // Window decode, alignment and acceptance for the incoming request
    always_comb begin
        ram_off  = bus.req_addr - RAM_BASE;
        mmio_off = bus.req_addr - MMIO_BASE;
        ram_hit  = ram_off < RAM_SPAN;
        mmio_hit = !ram_hit && (mmio_off < MMIO_SPAN);
        ram_idx  = ram_off[RAW+1:2];
        mmio_idx = mmio_off[MAW+1:2];
        case (bus.req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
        req_err = misaligned || !(ram_hit || mmio_hit);
        accept  = bus.req_valid && !busy;
    end

    // Replicate store data across lanes and pick the byte enables for the size
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                wr_be   = 4'b0001 << bus.req_addr[1:0];
                wr_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // Read the addressed word, right-justify the lane and extend it
    always_comb begin
        rd_word = ram_hit ? ram[ram_idx] : mmio[mmio_idx];
        rd_lane = rd_word >> {bus.req_addr[1:0], 3'b000};
        case (bus.req_size)
            2'b00:   ld_data = bus.req_signed ? {{24{rd_lane[7]}}, rd_lane[7:0]}
                                              : {24'b0, rd_lane[7:0]};
            2'b01:   ld_data = bus.req_signed ? {{16{rd_lane[15]}}, rd_lane[15:0]}
                                              : {16'b0, rd_lane[15:0]};
            default: ld_data = rd_lane;
        endcase
    end

    // Array writes: only accepted, aligned, mapped stores touch the enabled lanes
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    if (ram_hit) ram[ram_idx][8*k +: 8] <= wr_data[8*k +: 8];
                    else         mmio[mmio_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // One-cycle response register; data is zero for stores and errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept && req_err;
            rsp_rdata_q <= (accept && !req_err && !bus.req_we) ? ld_data : 32'h0;
        end
    end

    assign cur_byte  = 8'(buf_q >> {ptr_q[1:0], 3'b000});
    assign ptr_inc   = ptr_q + 32'd1;
    assign fetch_idx = RAW'((ptr_q - RAM_BASE) >> 2);

    // Print engine next-state and character-port outputs
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        fetch       = 1'b0;
        adv         = 1'b0;
        chr_valid_c = 1'b0;
        chr_data_c  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (bus.sys_valid && bus.sys_v == 32'd4) begin
                    start   = 1'b1;
                    state_d = in_ram(bus.sys_a) ? S_FETCH : S_NL;
                end
            end
            S_FETCH: begin
                fetch   = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                chr_data_c = cur_byte;
                if (cur_byte == 8'h00 || count_q == CW'(MAX_STR)) begin
                    state_d = S_NL;
                end else begin
                    chr_valid_c = 1'b1;
                    if (bus.chr_ready) begin
                        adv = 1'b1;
                        if (!in_ram(ptr_inc))           state_d = S_NL;
                        else if (ptr_inc[1:0] == 2'b00) state_d = S_FETCH;
                    end
                end
            end
            S_NL: begin
                chr_valid_c = 1'b1;
                chr_data_c  = 8'h0A;
                if (bus.chr_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // String pointer, emitted-byte count and fetched word buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= 32'h0;
            count_q <= '0;
            buf_q   <= 32'h0;
        end else begin
            if (start) begin
                ptr_q   <= bus.sys_a;
                count_q <= '0;
            end else if (adv) begin
                ptr_q   <= ptr_inc;
                count_q <= count_q + 1'b1;
            end
            if (fetch) buf_q <= ram[fetch_idx];
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.sys_busy  = busy;
    assign bus.stall     = busy;
    assign bus.chr_valid = chr_valid_c;
    assign bus.chr_data  = chr_data_c;
endmodule

// File: tb/tb_datamem_param.sv
// tb/tb_datamem_param.sv - self-checking bench for datamem_param
module tb_datamem_param;
    localparam longint unsigned RAM_BASE   = 64'h0010_0000;
    localparam longint unsigned RAM_WORDS  = 8192;
    localparam longint unsigned MMIO_BASE  = 64'hFFFF_0000;
    localparam longint unsigned MMIO_WORDS = 256;
    localparam int              TB_MAX_STR = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    datamem_param_if bus();

    datamem_param #(
        .RAM_BASE(32'h0010_0000), .RAM_WORDS(8192),
        .MMIO_BASE(32'hFFFF_0000), .MMIO_WORDS(256), .MAX_STR(TB_MAX_STR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_m [logic [31:0]];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_in_ram(input logic [31:0] a);
        longint unsigned la = a;
        return la >= RAM_BASE && la < RAM_BASE + 4 * RAM_WORDS;
    endfunction

    function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz);
        longint unsigned la = a;
        logic mapped = m_in_ram(a) || (la >= MMIO_BASE && la < MMIO_BASE + 4 * MMIO_WORDS);
        logic mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        return !mapped || mis;
    endfunction

    function automatic logic [7:0] m_byte(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : 8'h00;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sgn);
        int n = 1 << sz;
        logic [31:0] v = 32'h0;
        if (m_err(a, sz)) return 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(m_byte(a + 32'(i))) << (8 * i));
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) mem_m[a + 32'(i)] = 8'(wd >> (8 * i));
    endfunction

    function automatic void m_string(input logic [31:0] a);
        logic [31:0] p = a;
        exp_q.delete();
        while (m_in_ram(p) && exp_q.size() < TB_MAX_STR && m_byte(p) != 8'h00) begin
            exp_q.push_back(m_byte(p));
            p = p + 32'd1;
        end
        exp_q.push_back(8'h0A);
    endfunction

    task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic sgn,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_signed = sgn; bus.req_addr = a; bus.req_wdata = wd;
        if (we && !m_err(a, sz)) m_store(a, sz, wd);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, "_valid"}, bus.rsp_valid, 1);
        chk({tag, "_rdata"}, bus.rsp_rdata, er);
        chk({tag, "_err"}, bus.rsp_err, ee);
        @(negedge clk);
        chk({tag, "_valid_drop"}, bus.rsp_valid, 0);
    endtask

    task automatic run_print(input string tag, input logic [31:0] a, input int hold_at);
        logic stall_ok = 1'b1, stable_ok = 1'b1, done = 1'b0, stuck = 1'b0;
        logic [7:0] last_d = 8'h00;
        int hold = 0;
        m_string(a);
        got_q.delete();
        @(negedge clk);
        bus.sys_valid = 1'b1; bus.sys_v = 32'd4; bus.sys_a = a; bus.chr_ready = 1'b1;
        @(negedge clk);
        bus.sys_valid = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (bus.stall !== 1'b1 || bus.sys_busy !== 1'b1) stall_ok = 1'b0;
            if (stuck && (bus.chr_valid !== 1'b1 || bus.chr_data !== last_d)) stable_ok = 1'b0;
            if (hold > 0) begin bus.chr_ready = 1'b0; hold--; end
            else bus.chr_ready = 1'b1;
            if (bus.chr_valid === 1'b1 && bus.chr_ready) begin
                got_q.push_back(bus.chr_data);
                if (got_q.size() == hold_at) hold = 3;
                if (bus.chr_data == 8'h0A) done = 1'b1;
            end
            stuck  = (bus.chr_valid === 1'b1) && !bus.chr_ready;
            last_d = bus.chr_data;
            @(negedge clk);
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_stall"}, stall_ok, 1);
        chk({tag, "_stable"}, stable_ok, 1);
        chk({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_chr%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, "_idle_busy"}, bus.sys_busy, 0);
        chk({tag, "_idle_chr"}, bus.chr_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] unm [4] = '{32'h000F_FFFC, 32'h0010_8000, 32'hFFFF_0400, 32'h0042_0000};
        logic        pend, pe, quiet;
        logic [31:0] pd, a, wd;
        logic [1:0]  sz;
        logic        we, sgn;
        int          w;

        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0;
        bus.sys_valid = 0; bus.sys_v = 0; bus.sys_a = 0; bus.chr_ready = 1;

        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_busy", bus.sys_busy, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_chr_valid", bus.chr_valid, 0);
        chk("rst_chr_data", bus.chr_data, 0);
        rst_n = 1'b1;

        op("st_w",      1, 2'd2, 0, 32'h0010_0000, 32'hDEAD_BEEF, 32'h0, 0);
        op("ld_w",      0, 2'd2, 0, 32'h0010_0000, 32'h0, 32'hDEAD_BEEF, 0);
        op("st_unmap",  1, 2'd2, 0, 32'h0042_0000, 32'h1234_5678, 32'h0, 1);
        op("ld_after",  0, 2'd2, 0, 32'h0010_0000, 32'h0, 32'hDEAD_BEEF, 0);
        op("clr_w1",    1, 2'd2, 0, 32'h0010_0004, 32'h0, 32'h0, 0);
        op("st_b",      1, 2'd0, 0, 32'h0010_0005, 32'h0000_0080, 32'h0, 0);
        op("ld_bs",     0, 2'd0, 1, 32'h0010_0005, 32'h0, 32'hFFFF_FF80, 0);
        op("ld_bu",     0, 2'd0, 0, 32'h0010_0005, 32'h0, 32'h0000_0080, 0);
        op("ld_w1",     0, 2'd2, 0, 32'h0010_0004, 32'h0, 32'h0000_8000, 0);
        op("ld_h_mis",  0, 2'd1, 0, 32'h0010_0001, 32'h0, 32'h0, 1);
        op("ld_sz3",    0, 2'd3, 0, 32'h0010_0000, 32'h0, 32'h0, 1);
        op("st_mmio",   1, 2'd2, 0, 32'hFFFF_0010, 32'hCAFE_F00D, 32'h0, 0);
        op("ld_mmio",   0, 2'd2, 0, 32'hFFFF_0010, 32'h0, 32'hCAFE_F00D, 0);
        op("ld_mmio_h", 0, 2'd1, 1, 32'hFFFF_0012, 32'h0, 32'hFFFF_CAFE, 0);
        op("st_top",    1, 2'd2, 0, 32'h0010_7FFC, 32'h55AA_1234, 32'h0, 0);
        op("ld_top",    0, 2'd1, 0, 32'h0010_7FFE, 32'h0, 32'h0000_55AA, 0);
        op("ld_past",   0, 2'd0, 0, 32'h0010_8000, 32'h0, 32'h0, 1);
        op("ld_below",  0, 2'd2, 0, 32'hFFFE_FFFC, 32'h0, 32'h0, 1);

        for (int i = 0; i < 4; i++) begin
            op("clr_ram",  1, 2'd2, 0, 32'h0010_0000 + 32'(4 * i), 32'h0, 32'h0, 0);
            op("clr_mmio", 1, 2'd2, 0, 32'hFFFF_0000 + 32'(4 * i), 32'h0, 32'h0, 0);
        end

        pend = 1'b0; pe = 1'b0; pd = 32'h0;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (pend) begin
                chk("rnd_valid", bus.rsp_valid, 1);
                chk("rnd_rdata", bus.rsp_rdata, pd);
                chk("rnd_err", bus.rsp_err, pe);
            end else begin
                chk("rnd_idle", bus.rsp_valid, 0);
            end
            pend = 1'b0;
            bus.req_valid = 1'b0;
            if (i < 300 && $urandom_range(0, 3) != 0) begin
                w = $urandom_range(0, 9);
                if (w < 6)      a = 32'h0010_0000 + 32'($urandom_range(0, 15));
                else if (w < 9) a = 32'hFFFF_0000 + 32'($urandom_range(0, 15));
                else            a = unm[$urandom_range(0, 3)];
                sz  = 2'($urandom_range(0, 3));
                we  = 1'($urandom_range(0, 1));
                sgn = 1'($urandom_range(0, 1));
                wd  = $urandom;
                pe  = m_err(a, sz);
                pd  = (we || pe) ? 32'h0 : m_load(a, sz, sgn);
                if (we && !pe) m_store(a, sz, wd);
                bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
                bus.req_signed = sgn; bus.req_addr = a; bus.req_wdata = wd;
                pend = 1'b1;
            end
        end

        op("str_w0", 1, 2'd2, 0, 32'h0010_0000, 32'h6948_0000, 32'h0, 0);
        op("str_w1", 1, 2'd2, 0, 32'h0010_0004, 32'h0000_0021, 32'h0, 0);
        run_print("hi", 32'h0010_0002, 0);
        run_print("hi_hold", 32'h0010_0002, 1);

        @(negedge clk);
        bus.sys_valid = 1'b1; bus.sys_v = 32'd1; bus.sys_a = 32'h0010_0002;
        @(negedge clk);
        bus.sys_valid = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.sys_busy !== 1'b0 || bus.chr_valid !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        chk("sys_v1_quiet", quiet, 1);

        op("long_w0", 1, 2'd2, 0, 32'h0010_0040, 32'h4342_4100, 32'h0, 0);
        op("long_w1", 1, 2'd2, 0, 32'h0010_0044, 32'h4746_4544, 32'h0, 0);
        op("long_w2", 1, 2'd2, 0, 32'h0010_0048, 32'h0000_0048, 32'h0, 0);
        run_print("maxstr", 32'h0010_0041, 0);
        run_print("unmapped", 32'h0042_0000, 0);

        @(negedge clk);
        bus.sys_valid = 1'b1; bus.sys_v = 32'd4; bus.sys_a = 32'h0010_0002; bus.chr_ready = 1'b0;
        @(negedge clk);
        bus.sys_valid = 1'b0;
        w = 0;
        while (bus.chr_valid !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("rst_emit_reached", bus.chr_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_chr_valid", bus.chr_valid, 0);
        chk("arst_chr_data", bus.chr_data, 0);
        chk("arst_busy", bus.sys_busy, 0);
        chk("arst_stall", bus.stall, 0);
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.chr_ready = 1'b1;
        run_print("after_rst", 32'h0010_0002, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/datamem_param.md
Name: datamem_param

Overview:
- Parametrised successor to the single-cycle data memory.
- Has a configurable RAM window and MMIO window, and byte/half/word stores with little-endian lanes.
- Loads are registered, sign- or zero-extended, and signal alignment/range errors.
- Syscall 4 (print string) runs as a cycle-by-cycle engine that streams characters over a valid/ready port instead of a blocking loop. The block sits in the MEM stage and drives a stall to the pipeline while the engine is busy.

Parameters:
- RAM_BASE, 32'h0010_0000, byte address of RAM word 0.
- RAM_WORDS, 8192, number of 32-bit RAM words; must be a power of 2.
- MMIO_BASE, 32'hFFFF_0000, byte address of MMIO word 0.
- MMIO_WORDS, 256, number of 32-bit MMIO words.
- MAX_STR, 1024, maximum number of bytes the print engine emits before forcing termination.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  memory request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal (treated as misaligned).
- req_signed  in  1  sign-extend byte/half loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response for the request accepted in the previous cycle.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned or unmapped access.
- stall  out  1  pipeline must hold; high whenever sys_busy is high.
- sys_valid  in  1  syscall strobe (one cycle).
- sys_v  in  32  $v0 value (syscall code).
- sys_a  in  32  $a0 value (string start byte address).
- sys_busy  out  1  print engine active.
- chr_valid  out  1  character available.
- chr_data  out  8  character byte.
- chr_ready  in  1  consumer accepts the character.

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid, rsp_rdata, rsp_err, sys_busy, stall, chr_valid, chr_data all 0; FSM goes to IDLE. Array contents are not cleared by reset; they are zero at simulation start.
- Address decode:
  - RAM hit: RAM_BASE <= addr < RAM_BASE + 4*RAM_WORDS.
  - MMIO hit: MMIO_BASE <= addr < MMIO_BASE + 4*MMIO_WORDS.
  - Word index = (addr - base) >> 2.
  - Anything outside both windows is unmapped.
- Alignment: a half access with addr[0]=1, a word access with addr[1:0]!=0, or size 11 is misaligned.
- Request acceptance: a request is accepted when req_valid=1 and sys_busy=0. Requests arriving while busy are ignored; the pipeline must hold them because stall is high.
- Latency: exactly 1 cycle. rsp_valid=1 in the cycle after acceptance; otherwise rsp_valid=0.
- Store:
  - Lane select: byte lane = addr[1:0]; half lane = addr[1].
  - Byte k occupies word bits [8k+7:8k]. Only the selected lanes are written.
  - Error (misaligned or unmapped): no write, rsp_err=1.
- Load:
  - The selected lane is right-justified.
  - If req_signed=1, the top bit of the lane is extended; otherwise zero-filled.
  - Error: rsp_rdata=0, rsp_err=1.
- Read-after-write: a store at cycle N followed by a load to the same address at cycle N+1 returns the new data. The array write is visible on the next cycle.
- Syscall trigger: in IDLE, sys_valid=1 with sys_v==4 starts the engine. Any other code is ignored (no state change). sys_valid outside IDLE is ignored.
- FSM states:
  - IDLE: sys_busy=0.
    - On trigger: capture ptr=sys_a, count=0. Go to FETCH if sys_a is in RAM, else go to NL.
  - FETCH: latch RAM word at ptr>>2 into a buffer; lane = ptr[1:0]; go to EMIT. sys_busy=1 from this state through NL.
  - EMIT: chr_data = buffer lane, chr_valid=1.
    - If the byte is 0: drop chr_valid and go to NL (the 0 is not emitted).
    - If count == MAX_STR: go to NL without emitting.
    - On chr_ready: ptr+1 and count+1. If the new lane is 0 (word crossed) or ptr leaves RAM, go to FETCH, or to NL if out of RAM; otherwise stay in EMIT.
  - NL: chr_data=8'h0A, chr_valid=1; on chr_ready go to IDLE.
- Output stability: chr_data and chr_valid hold steady while chr_valid=1 and chr_ready=0.
- Strings start at any byte alignment. Termination is on the first zero byte, not on a zero word.
- Reset during the engine aborts it immediately; chr_valid drops asynchronously.

Test Plan:
- Store word 32'hDEADBEEF @0x0010_0000, then load word → rsp_rdata=DEADBEEF, rsp_err=0, rsp_valid exactly one cycle after the request.
- Byte store 0x80 @0x0010_0005, then load byte signed → FFFF_FF80; load byte unsigned → 0000_0080; load word @0x0010_0004 → 0000_8000 (other lanes untouched).
- Half load @0x0010_0001 → rsp_err=1, rsp_rdata=0; word store @0x0042_0000 (unmapped) → rsp_err=1, no array change; store/load @0xFFFF_0010 works (MMIO).
- RAM holds "Hi!" + 0 at 0x0010_0002, i.e. word 0=0x6948_xxxx, word 1=0x0000_0021. Pulse sys_valid with sys_v=4, sys_a=0x0010_0002, chr_ready=1 → chr stream 'H','i','!',0x0A; stall high throughout, then back to IDLE.
- Same string with chr_ready low for 3 cycles mid-string → chr_data held stable, no byte dropped or duplicated; sys_valid with sys_v=1 → no activity.
- Assert rst_n low during EMIT → all outputs 0 immediately; a new syscall after reset prints correctly from the start.
